// File: rtl/calcn_core.sv
// calcn_core: N-port calculator core sharing one ALU.
//
// Each port runs a small request FSM (IDLE -> OP2 -> PEND). In IDLE, a non-zero
// command latches cmd and op1. The next cycle latches op2 and ignores the cmd
// field. The port then waits in PEND until the round-robin arbiter grants it
// the ALU. The result is registered at the end of the grant cycle and is
// presented for exactly one cycle.
//
// Ports (all flat vectors are big-endian, port p at the lowest indices 4p / 2p / DATA_W*p):
//   c_clk     in   core clock, rising edge
//   reset     in   synchronous active-high reset
//   req_cmd   in   [0:4*NUM_PORTS-1]       per-port command (0 nop,1 add,2 sub,5 shl,6 shr)
//   req_data  in   [0:DATA_W*NUM_PORTS-1]  per-port operand (op1 with cmd, op2 next cycle)
//   out_resp  out  [0:2*NUM_PORTS-1]       per-port response (00 none,01 ok,10 error)
//   out_data  out  [0:DATA_W*NUM_PORTS-1]  per-port result
//
// Build option: define CALCN_SAT_EN for saturating add/sub. With it, add
// overflow returns all-ones and sub underflow returns zero, both with resp 01.
module calcn_core #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SH_W      = 5
) (
  input  logic                         c_clk,
  input  logic                         reset,
  input  logic [0:4*NUM_PORTS-1]       req_cmd,
  input  logic [0:DATA_W*NUM_PORTS-1]  req_data,
  output logic [0:2*NUM_PORTS-1]       out_resp,
  output logic [0:DATA_W*NUM_PORTS-1]  out_data
);

  localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {StIdle, StOp2, StPend} state_e;

  state_e                           state_q [NUM_PORTS];
  state_e                           state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0][3:0]        cmd_q, cmd_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [NUM_PORTS-1:0][1:0]        resp_q, resp_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] res_q, res_d;
  logic [PtrW-1:0]                  ptr_q, ptr_d;

  logic            gnt_vld;
  logic [PtrW-1:0] gnt_idx;
  int unsigned     cand;

  // First PEND port at or after the pointer, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!gnt_vld && state_q[PtrW'(cand)] == StPend) begin
        gnt_vld = 1'b1;
        gnt_idx = PtrW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == PtrW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Shared ALU operating on the granted port's latched request.
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_a, alu_b, alu_data;
  logic [DATA_W:0]   alu_sum;
  logic [1:0]        alu_resp;

  always_comb begin
    alu_cmd  = cmd_q[gnt_idx];
    alu_a    = op1_q[gnt_idx];
    alu_b    = op2_q[gnt_idx];
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_resp = 2'b10;
    alu_data = '0;
    case (alu_cmd)
      4'd1: begin
        if (alu_sum[DATA_W]) begin
`ifdef CALCN_SAT_EN
          alu_resp = 2'b01;
          alu_data = '1;
`else
          alu_resp = 2'b10;
          alu_data = '0;
`endif
        end else begin
          alu_resp = 2'b01;
          alu_data = alu_sum[DATA_W-1:0];
        end
      end
      4'd2: begin
        if (alu_b > alu_a) begin
`ifdef CALCN_SAT_EN
          alu_resp = 2'b01;
`else
          alu_resp = 2'b10;
`endif
          alu_data = '0;
        end else begin
          alu_resp = 2'b01;
          alu_data = alu_a - alu_b;
        end
      end
      4'd5: begin
        alu_resp = 2'b01;
        alu_data = alu_a << alu_b[SH_W-1:0];
      end
      4'd6: begin
        alu_resp = 2'b01;
        alu_data = alu_a >> alu_b[SH_W-1:0];
      end
      default: begin
        alu_resp = 2'b10;
        alu_data = '0;
      end
    endcase
  end

  // Per-port request FSMs and one-cycle response registers.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      cmd_d[p]   = cmd_q[p];
      op1_d[p]   = op1_q[p];
      op2_d[p]   = op2_q[p];
      resp_d[p]  = 2'b00;
      res_d[p]   = '0;
      case (state_q[p])
        StIdle: begin
          if (req_cmd[4*p +: 4] != 4'd0) begin
            cmd_d[p]   = req_cmd[4*p +: 4];
            op1_d[p]   = req_data[DATA_W*p +: DATA_W];
            state_d[p] = StOp2;
          end
        end
        StOp2: begin
          op2_d[p]   = req_data[DATA_W*p +: DATA_W];
          state_d[p] = StPend;
        end
        StPend: begin
          if (gnt_vld && 32'(gnt_idx) == p) state_d[p] = StIdle;
        end
        default: state_d[p] = StIdle;
      endcase
    end
    if (gnt_vld) begin
      resp_d[gnt_idx] = alu_resp;
      res_d[gnt_idx]  = alu_data;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) state_q[p] <= StIdle;
      cmd_q  <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      resp_q <= '0;
      res_q  <= '0;
      ptr_q  <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) state_q[p] <= state_d[p];
      cmd_q  <= cmd_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      resp_q <= resp_d;
      res_q  <= res_d;
      ptr_q  <= ptr_d;
    end
  end

  always_comb begin
    out_resp = '0;
    out_data = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      out_resp[2*p +: 2]           = resp_q[p];
      out_data[DATA_W*p +: DATA_W] = res_q[p];
    end
  end

endmodule

// File: tb/tb_calcn_core.sv
// tb_calcn_core: directed self-checking bench for calcn_core (4 ports, 32-bit).
module tb_calcn_core;

  localparam int NP = 4;
  localparam int DW = 32;

  logic                c_clk;
  logic                reset;
  logic [0:4*NP-1]     req_cmd;
  logic [0:DW*NP-1]    req_data;
  logic [0:2*NP-1]     out_resp;
  logic [0:DW*NP-1]    out_data;

  int n_checks = 0;
  int n_fail   = 0;

  calcn_core #(
    .NUM_PORTS(NP),
    .DATA_W   (DW),
    .SH_W     (5)
  ) dut (
    .c_clk   (c_clk),
    .reset   (reset),
    .req_cmd (req_cmd),
    .req_data(req_data),
    .out_resp(out_resp),
    .out_data(out_data)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [3:0] c, input logic [31:0] d);
    req_cmd[4*p +: 4]   = c;
    req_data[DW*p +: DW] = d;
  endtask

  task automatic idle_all();
    req_cmd  = '0;
    req_data = '0;
  endtask

  function automatic logic [1:0] resp_of(input int p);
    return out_resp[2*p +: 2];
  endfunction

  function automatic logic [31:0] data_of(input int p);
    return out_data[DW*p +: DW];
  endfunction

  // Issues one request on port p alone; returns what the port shows at T+3.
  task automatic run_single(input int p, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, output logic [1:0] r,
                            output logic [31:0] d);
    drive(p, c, a);
    tick();
    drive(p, 4'd0, b);
    tick();
    idle_all();
    tick();
    r = resp_of(p);
    d = data_of(p);
    tick();
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (out_resp !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h want 0", out_resp);
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    // Command in the release cycle.
    reset = 1'b0;
    drive(0, 4'd1, 32'd3);
    tick();
    drive(0, 4'd0, 32'd4);
    tick();
    idle_all();
    tick();
    n_checks++;
    if (resp_of(0) !== 2'b01 || data_of(0) !== 32'd7) begin
      n_fail++;
      $display("FAIL release_cmd: got %b/%h want 01/7", resp_of(0), data_of(0));
    end
    tick();
  endtask

  task automatic test_add();
    drive(0, 4'd1, 32'h0000_0001);
    tick();
    drive(0, 4'd0, 32'h1FFF_FFFF);
    tick();
    idle_all();
    n_checks++;
    if (out_resp !== '0) begin
      n_fail++;
      $display("FAIL add_t2_early: got %h want 0", out_resp);
    end
    tick();
    n_checks++;
    if (resp_of(0) !== 2'b01 || data_of(0) !== 32'h2000_0000) begin
      n_fail++;
      $display("FAIL add_t3: got %b/%h want 01/20000000", resp_of(0), data_of(0));
    end
    tick();
    n_checks++;
    if (out_resp !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL add_t4_clear: got %h/%h want 0/0", out_resp, out_data);
    end
  endtask

  task automatic test_overflow();
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  er;
    logic [31:0] ed;
`ifdef CALCN_SAT_EN
    er = 2'b01;
    ed = 32'hFFFF_FFFF;
`else
    er = 2'b10;
    ed = 32'h0;
`endif
    run_single(2, 4'd1, 32'hFFFF_FFFF, 32'h1, r, d);
    n_checks++;
    if (r !== er || d !== ed) begin
      n_fail++;
      $display("FAIL add_overflow: got %b/%h want %b/%h", r, d, er, ed);
    end
  endtask

  task automatic test_sub_invalid();
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  er;
`ifdef CALCN_SAT_EN
    er = 2'b01;
`else
    er = 2'b10;
`endif
    run_single(1, 4'd2, 32'h1, 32'hF, r, d);
    n_checks++;
    if (r !== er || d !== 32'h0) begin
      n_fail++;
      $display("FAIL sub_underflow: got %b/%h want %b/0", r, d, er);
    end
    run_single(1, 4'd2, 32'hF, 32'h1, r, d);
    n_checks++;
    if (r !== 2'b01 || d !== 32'hE) begin
      n_fail++;
      $display("FAIL sub_ok: got %b/%h want 01/e", r, d);
    end
    run_single(3, 4'd4, 32'h5, 32'h5, r, d);
    n_checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL invalid_cmd4: got %b/%h want 10/0", r, d);
    end
    run_single(3, 4'd15, 32'h5, 32'h5, r, d);
    n_checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL invalid_cmd15: got %b/%h want 10/0", r, d);
    end
  endtask

  task automatic test_shift();
    logic [1:0]  r;
    logic [31:0] d;
    run_single(0, 4'd5, 32'h1, 32'h1F, r, d);
    n_checks++;
    if (r !== 2'b01 || d !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL shl: got %b/%h want 01/80000000", r, d);
    end
    run_single(0, 4'd6, 32'h8000_0000, 32'h4, r, d);
    n_checks++;
    if (r !== 2'b01 || d !== 32'h0800_0000) begin
      n_fail++;
      $display("FAIL shr: got %b/%h want 01/08000000", r, d);
    end
    // Only the low 5 bits of op2 count as the shift amount.
    run_single(0, 4'd5, 32'h3, 32'hFFFF_FFE1, r, d);
    n_checks++;
    if (r !== 2'b01 || d !== 32'h6) begin
      n_fail++;
      $display("FAIL shl_mask: got %b/%h want 01/6", r, d);
    end
  endtask

  // All ports issue add in the same cycle; checks grant order from the given first port.
  task automatic all_ports(input int first);
    logic [0:2*NP-1] er;
    int q;
    for (int p = 0; p < NP; p++) drive(p, 4'd1, 32'h100 * (p + 1));
    tick();
    for (int p = 0; p < NP; p++) drive(p, 4'd0, p + 1);
    tick();
    idle_all();
    tick();
    for (int k = 0; k < NP; k++) begin
      q  = (first + k) % NP;
      er = '0;
      er[2*q +: 2] = 2'b01;
      n_checks++;
      if (out_resp !== er || data_of(q) !== 32'h100 * (q + 1) + q + 1) begin
        n_fail++;
        $display("FAIL rr_first%0d_slot%0d: got %h/%h want %h/%h", first, k, out_resp,
                 data_of(q), er, 32'h100 * (q + 1) + q + 1);
      end
      tick();
    end
  endtask

  task automatic test_all_ports();
    logic [1:0]  r;
    logic [31:0] d;
    run_single(3, 4'd1, 32'h2, 32'h3, r, d);  // pointer -> 0
    n_checks++;
    if (r !== 2'b01 || d !== 32'h5) begin
      n_fail++;
      $display("FAIL pre_rr0: got %b/%h want 01/5", r, d);
    end
    all_ports(0);
    run_single(1, 4'd1, 32'h2, 32'h3, r, d);  // pointer -> 2
    n_checks++;
    if (r !== 2'b01 || d !== 32'h5) begin
      n_fail++;
      $display("FAIL pre_rr2: got %b/%h want 01/5", r, d);
    end
    all_ports(2);
  endtask

  task automatic test_back_to_back();
    drive(1, 4'd1, 32'd5);
    tick();
    drive(1, 4'd0, 32'd6);
    tick();
    idle_all();
    tick();
    n_checks++;
    if (resp_of(1) !== 2'b01 || data_of(1) !== 32'd11) begin
      n_fail++;
      $display("FAIL b2b_first: got %b/%h want 01/b", resp_of(1), data_of(1));
    end
    drive(1, 4'd2, 32'd20);  // new cmd in the response cycle
    tick();
    n_checks++;
    if (resp_of(1) !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_gap: got %b want 00", resp_of(1));
    end
    drive(1, 4'd0, 32'd7);
    tick();
    idle_all();
    tick();
    n_checks++;
    if (resp_of(1) !== 2'b01 || data_of(1) !== 32'd13) begin
      n_fail++;
      $display("FAIL b2b_second: got %b/%h want 01/d", resp_of(1), data_of(1));
    end
    tick();
  endtask

  task automatic test_drop();
    int cnt;
    drive(0, 4'd1, 32'd10);
    tick();
    drive(0, 4'd1, 32'd20);  // cmd field ignored in OP2
    tick();
    drive(0, 4'd2, 32'd99);  // presented while PEND: dropped
    tick();
    idle_all();
    n_checks++;
    if (resp_of(0) !== 2'b01 || data_of(0) !== 32'd30) begin
      n_fail++;
      $display("FAIL drop_resp: got %b/%h want 01/1e", resp_of(0), data_of(0));
    end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_resp !== '0) cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== 1) begin
      n_fail++;
      $display("FAIL drop_count: got %0d responses want 1", cnt);
    end
  endtask

  task automatic test_reset_op2();
    logic [1:0]  r;
    logic [31:0] d;
    int cnt;
    drive(0, 4'd1, 32'd5);
    tick();
    reset = 1'b1;
    drive(0, 4'd0, 32'd6);
    tick();
    reset = 1'b0;
    idle_all();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_resp !== '0) cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d responses want 0", cnt);
    end
    run_single(0, 4'd1, 32'd5, 32'd6, r, d);
    n_checks++;
    if (r !== 2'b01 || d !== 32'd11) begin
      n_fail++;
      $display("FAIL after_reset: got %b/%h want 01/b", r, d);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_add();
    test_overflow();
    test_sub_invalid();
    test_shift();
    test_all_ports();
    test_back_to_back();
    test_drop();
    test_reset_op2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
